// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: serializes single-word SPI and host requests onto one 3-cycle memory port.
// Define SPI_PRIORITY_EN for fixed SPI-wins-ties arbitration; default build is round-robin.
module spi_mem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              spi_req_i,
  input  logic              spi_we_i,
  input  logic [ADDR_W-1:0] spi_addr_i,
  input  logic [DATA_W-1:0] spi_wdata_i,
  output logic              spi_ack_o,
  output logic [DATA_W-1:0] spi_rdata_o,
  output logic              spi_busy_o,
  output logic              spi_ovf_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_ack_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic {HOST = 1'b0, SPI = 1'b1} side_e;

  state_e            state_q, state_d;
  side_e             owner_q, owner_d, winner;
  logic              op_we_q, op_we_d;
  logic              spi_pend_q, spi_pend_d;
  logic              spi_we_q, spi_we_d;
  logic [ADDR_W-1:0] spi_addr_q, spi_addr_d;
  logic [DATA_W-1:0] spi_wdata_q, spi_wdata_d;
  logic              spi_ovf_q, spi_ovf_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              spi_ack_q, spi_ack_d;
  logic              host_ack_q, host_ack_d;
  logic [DATA_W-1:0] spi_rdata_q, spi_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
`ifndef SPI_PRIORITY_EN
  side_e             last_q, last_d;
`endif

  logic              host_elig, spi_elig, spi_clear, spi_take;
  logic              spi_sel_we;
  logic [ADDR_W-1:0] spi_sel_addr;
  logic [DATA_W-1:0] spi_sel_wdata;

  // A fresh SPI pulse in IDLE is granted directly, bypassing the buffer it also fills.
  always_comb begin
    host_elig     = host_req_i & ~host_ack_q;
    spi_elig      = spi_pend_q | spi_req_i;
    spi_clear     = (state_q == RESP) && (owner_q == SPI);
    spi_take      = spi_req_i & (~spi_pend_q | spi_clear);
    spi_sel_we    = spi_pend_q ? spi_we_q    : spi_we_i;
    spi_sel_addr  = spi_pend_q ? spi_addr_q  : spi_addr_i;
    spi_sel_wdata = spi_pend_q ? spi_wdata_q : spi_wdata_i;
`ifdef SPI_PRIORITY_EN
    if (spi_elig) winner = SPI;
    else          winner = HOST;
`else
    if (spi_elig && host_elig) begin
      if (last_q == HOST) winner = SPI;
      else                winner = HOST;
    end else if (spi_elig) begin
      winner = SPI;
    end else begin
      winner = HOST;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      owner_q      <= HOST;
      op_we_q      <= 1'b0;
      spi_pend_q   <= 1'b0;
      spi_we_q     <= 1'b0;
      spi_addr_q   <= '0;
      spi_wdata_q  <= '0;
      spi_ovf_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      spi_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      spi_rdata_q  <= '0;
      host_rdata_q <= '0;
`ifndef SPI_PRIORITY_EN
      last_q       <= HOST;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      op_we_q      <= op_we_d;
      spi_pend_q   <= spi_pend_d;
      spi_we_q     <= spi_we_d;
      spi_addr_q   <= spi_addr_d;
      spi_wdata_q  <= spi_wdata_d;
      spi_ovf_q    <= spi_ovf_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      spi_ack_q    <= spi_ack_d;
      host_ack_q   <= host_ack_d;
      spi_rdata_q  <= spi_rdata_d;
      host_rdata_q <= host_rdata_d;
`ifndef SPI_PRIORITY_EN
      last_q       <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (host_elig || spi_elig) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A request landing on the ack edge refills the buffer; any other overlap is dropped and flagged.
  always_comb begin
    spi_pend_d   = spi_pend_q;
    spi_we_d     = spi_we_q;
    spi_addr_d   = spi_addr_q;
    spi_wdata_d  = spi_wdata_q;
    spi_ovf_d    = spi_ovf_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    owner_d      = owner_q;
    op_we_d      = op_we_q;
    spi_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    spi_rdata_d  = spi_rdata_q;
    host_rdata_d = host_rdata_q;
`ifndef SPI_PRIORITY_EN
    last_d       = last_q;
`endif
    if (spi_clear) spi_pend_d = 1'b0;
    if (spi_take) begin
      spi_pend_d  = 1'b1;
      spi_we_d    = spi_we_i;
      spi_addr_d  = spi_addr_i;
      spi_wdata_d = spi_wdata_i;
    end else if (spi_req_i) begin
      spi_ovf_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (host_elig || spi_elig) begin
          mem_en_d = 1'b1;
          owner_d  = winner;
          if (winner == SPI) begin
            mem_we_d    = spi_sel_we;
            mem_addr_d  = spi_sel_addr;
            mem_wdata_d = spi_sel_wdata;
          end else begin
            mem_we_d    = host_we_i;
            mem_addr_d  = host_addr_i;
            mem_wdata_d = host_wdata_i;
          end
          op_we_d = mem_we_d;
        end
      end
      RESP: begin
`ifndef SPI_PRIORITY_EN
        last_d = owner_q;
`endif
        if (owner_q == SPI) begin
          spi_ack_d = 1'b1;
          if (!op_we_q) spi_rdata_d = mem_rdata_i;
        end else begin
          host_ack_d = 1'b1;
          if (!op_we_q) host_rdata_d = mem_rdata_i;
        end
      end
      default: ;
    endcase
  end

  assign spi_ack_o    = spi_ack_q;
  assign spi_rdata_o  = spi_rdata_q;
  assign spi_busy_o   = spi_pend_q | ((owner_q == SPI) && (state_q != IDLE));
  assign spi_ovf_o    = spi_ovf_q;
  assign host_ack_o   = host_ack_q;
  assign host_rdata_o = host_rdata_q;
  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter against a 128x8 synchronous memory model.
// Tie-order expectations follow SPI_PRIORITY_EN when the same macro is defined for the bench.
`timescale 1ns/1ps
module tb_spi_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset, spi_req, spi_we, host_req, host_we;
  logic [6:0] spi_addr, host_addr, mem_addr;
  logic [7:0] spi_wdata, host_wdata, mem_wdata, mem_rdata, spi_rdata, host_rdata;
  logic       spi_ack, spi_busy, spi_ovf, host_ack, mem_en, mem_we;
  logic [7:0] mem [0:127];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  spi_mem_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk_i(clk), .reset_i(reset),
    .spi_req_i(spi_req), .spi_we_i(spi_we), .spi_addr_i(spi_addr), .spi_wdata_i(spi_wdata),
    .spi_ack_o(spi_ack), .spi_rdata_o(spi_rdata), .spi_busy_o(spi_busy), .spi_ovf_o(spi_ovf),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_ack_o(host_ack), .host_rdata_o(host_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  // Synchronous memory: read data appears the cycle after the sampling edge.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; spi_req = 1'b1; host_req = 1'b1;
    tick();
    tick();
    reset = 1'b0; spi_req = 1'b0; host_req = 1'b0;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, spi_ack, host_ack, spi_rdata, host_rdata, spi_busy, spi_ovf} !== 37'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h want=0", {mem_en, mem_we, mem_addr, mem_wdata, spi_ack, host_ack, spi_rdata, host_rdata, spi_busy, spi_ovf});
    end
    tick();
    checks++;
    if ({mem_en, spi_busy} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_idle got=%b want=00", {mem_en, spi_busy});
    end
  endtask

  task automatic test_host_rw();
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'h12; host_wdata = 8'hA5;
    tick();
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 7'h12, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL host_wr_grant got=%h want=%h", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 7'h12, 8'hA5});
    end
    tick();
    checks++;
    if ({mem_en, host_ack} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL host_wr_access got=%b want=00", {mem_en, host_ack});
    end
    tick();
    checks++;
    if (host_ack !== 1'b1) begin
      failures++;
      $display("[TB] FAIL host_wr_ack got=%b want=1", host_ack);
    end
    host_req = 1'b0;
    tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h12; host_wdata = 8'h00;
    tick();
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 7'h12}) begin
      failures++;
      $display("[TB] FAIL host_rd_grant got=%h want=%h", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 7'h12});
    end
    tick();
    tick();
    checks++;
    if ({host_ack, host_rdata} !== {1'b1, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL host_rd_ack got=%h want=%h", {host_ack, host_rdata}, {1'b1, 8'hA5});
    end
    host_req = 1'b0;
    tick();
    checks++;
    if ({host_ack, host_rdata} !== {1'b0, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL host_rd_hold got=%h want=%h", {host_ack, host_rdata}, {1'b0, 8'hA5});
    end
  endtask

  task automatic test_spi_rw();
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 7'h7F; spi_wdata = 8'h3C;
    tick();
    spi_req = 1'b0;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, spi_busy} !== {1'b1, 1'b1, 7'h7F, 8'h3C, 1'b1}) begin
      failures++;
      $display("[TB] FAIL spi_wr_grant got=%h want=%h", {mem_en, mem_we, mem_addr, mem_wdata, spi_busy}, {1'b1, 1'b1, 7'h7F, 8'h3C, 1'b1});
    end
    tick();
    checks++;
    if ({mem_en, spi_ack, spi_busy} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL spi_wr_access got=%b want=001", {mem_en, spi_ack, spi_busy});
    end
    tick();
    checks++;
    if (spi_ack !== 1'b1) begin
      failures++;
      $display("[TB] FAIL spi_wr_ack got=%b want=1", spi_ack);
    end
    tick();
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 7'h7F; spi_wdata = 8'h00;
    tick();
    spi_req = 1'b0;
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 7'h7F}) begin
      failures++;
      $display("[TB] FAIL spi_rd_grant got=%h want=%h", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 7'h7F});
    end
    tick();
    tick();
    checks++;
    if ({spi_ack, spi_rdata, host_rdata} !== {1'b1, 8'h3C, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL spi_rd_ack got=%h want=%h", {spi_ack, spi_rdata, host_rdata}, {1'b1, 8'h3C, 8'hA5});
    end
    tick();
    checks++;
    if ({spi_ack, spi_rdata, spi_busy} !== {1'b0, 8'h3C, 1'b0}) begin
      failures++;
      $display("[TB] FAIL spi_rd_hold got=%h want=%h", {spi_ack, spi_rdata, spi_busy}, {1'b0, 8'h3C, 1'b0});
    end
  endtask

  // Raises both requests in one cycle and reports the cycle each side is acked.
  task automatic run_tie(output int sCyc, output int hCyc);
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 7'h7F;
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h12;
    sCyc = -1;
    hCyc = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) spi_req = 1'b0;
      if (spi_ack && sCyc < 0) sCyc = c;
      if (host_ack && hCyc < 0) begin
        hCyc = c;
        host_req = 1'b0;
      end
    end
  endtask

  task automatic test_round_robin();
    int s, h;
    do_reset();
    run_tie(s, h);
    checks++;
    if (s !== 3 || h !== 6) begin
      failures++;
      $display("[TB] FAIL tie1_order got=spi@%0d host@%0d want=spi@3 host@6", s, h);
    end
    checks++;
    if ({spi_rdata, host_rdata} !== {8'h3C, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL tie1_data got=%h want=3ca5", {spi_rdata, host_rdata});
    end
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 7'h7F;
    tick();
    spi_req = 1'b0;
    tick();
    tick();
    checks++;
    if (spi_ack !== 1'b1) begin
      failures++;
      $display("[TB] FAIL solo_spi_ack got=%b want=1", spi_ack);
    end
    tick();
    run_tie(s, h);
`ifdef SPI_PRIORITY_EN
    checks++;
    if (s !== 3 || h !== 6) begin
      failures++;
      $display("[TB] FAIL tie2_order got=spi@%0d host@%0d want=spi@3 host@6", s, h);
    end
`else
    checks++;
    if (s !== 6 || h !== 3) begin
      failures++;
      $display("[TB] FAIL tie2_order got=spi@%0d host@%0d want=spi@6 host@3", s, h);
    end
`endif
  endtask

  task automatic test_ack_edge_req();
    do_reset();
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 7'h05; spi_wdata = 8'h11;
    tick();
    spi_req = 1'b0;
    tick();
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 7'h05; spi_wdata = 8'h00;
    tick();
    spi_req = 1'b0;
    checks++;
    if ({spi_ack, spi_ovf, spi_busy} !== 3'b101) begin
      failures++;
      $display("[TB] FAIL ackedge_capture got=%b want=101", {spi_ack, spi_ovf, spi_busy});
    end
    tick();
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 7'h05}) begin
      failures++;
      $display("[TB] FAIL ackedge_grant got=%h want=%h", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 7'h05});
    end
    tick();
    tick();
    checks++;
    if ({spi_ack, spi_rdata, spi_ovf} !== {1'b1, 8'h11, 1'b0}) begin
      failures++;
      $display("[TB] FAIL ackedge_read got=%h want=%h", {spi_ack, spi_rdata, spi_ovf}, {1'b1, 8'h11, 1'b0});
    end
  endtask

  task automatic test_overflow();
    do_reset();
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h12;
    tick();
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 7'h05; spi_wdata = 8'h44;
    tick();
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 7'h06; spi_wdata = 8'h22;
    tick();
    spi_req = 1'b0; host_req = 1'b0;
    checks++;
    if ({host_ack, host_rdata, spi_ovf, spi_busy} !== {1'b1, 8'hA5, 1'b1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL ovf_flag got=%h want=%h", {host_ack, host_rdata, spi_ovf, spi_busy}, {1'b1, 8'hA5, 1'b1, 1'b1});
    end
    tick();
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 7'h05, 8'h44}) begin
      failures++;
      $display("[TB] FAIL ovf_buffer got=%h want=%h", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 7'h05, 8'h44});
    end
    tick();
    tick();
    checks++;
    if ({spi_ack, spi_ovf} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL ovf_ack got=%b want=11", {spi_ack, spi_ovf});
    end
    tick();
    tick();
    tick();
    checks++;
    if ({spi_ovf, spi_busy} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL ovf_sticky got=%b want=10", {spi_ovf, spi_busy});
    end
    do_reset();
    checks++;
    if (spi_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_cleared got=%b want=0", spi_ovf);
    end
  endtask

  task automatic test_reset_mid_access();
    logic sawAck;
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h12;
    tick();
    checks++;
    if (mem_en !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_grant got=%b want=1", mem_en);
    end
    reset = 1'b1; host_req = 1'b0;
    tick();
    reset = 1'b0;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, spi_ack, host_ack, spi_rdata, host_rdata, spi_busy, spi_ovf} !== 37'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs got=%h want=0", {mem_en, mem_we, mem_addr, mem_wdata, spi_ack, host_ack, spi_rdata, host_rdata, spi_busy, spi_ovf});
    end
    sawAck = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (host_ack !== 1'b0) sawAck = 1'b1;
    end
    checks++;
    if (sawAck !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_no_ack got=%b want=0", sawAck);
    end
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h12;
    tick();
    tick();
    tick();
    host_req = 1'b0;
    checks++;
    if ({host_ack, host_rdata} !== {1'b1, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL mid_recover got=%h want=%h", {host_ack, host_rdata}, {1'b1, 8'hA5});
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem_rdata = 8'h00;
    reset = 1'b1; spi_req = 1'b0; spi_we = 1'b0; spi_addr = 7'h00; spi_wdata = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = 7'h00; host_wdata = 8'h00;
    test_reset();
    test_host_rw();
    test_spi_rw();
    test_round_robin();
    test_ack_edge_req();
    test_overflow();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
